// File: rtl/apb_slv_mem.sv
// apb_slv_mem: APB4 completer RAM with wait states, byte strobes, error response and sticky protocol flag
module apb_slv_mem #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_DATA_WIDTH  = 32,
  parameter int APB_STROB_WIDTH = APB_DATA_WIDTH / 8,
  parameter int MEM_DEPTH       = 256,
  parameter int SEC_BASE        = MEM_DEPTH / 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic [APB_ADDR_WIDTH-1:0]  PADDR,
  input  logic                       PWRITE,
  input  logic [APB_DATA_WIDTH-1:0]  PWDATA,
  input  logic [APB_STROB_WIDTH-1:0] PSTROB,
  input  logic [2:0]                 PPROT,
  input  logic [3:0]                 wait_cfg,
  output logic                       PREADY,
  output logic [APB_DATA_WIDTH-1:0]  PRDATA,
  output logic                       PSLVERR,
  output logic                       prot_err,
  output logic [15:0]                xfer_cnt
);
  localparam int OFS = $clog2(APB_STROB_WIDTH);
  localparam int IW  = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                     state_q;
  logic [APB_DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];
  logic [APB_ADDR_WIDTH-1:0]  addr_q;
  logic [APB_DATA_WIDTH-1:0]  data_q;
  logic [APB_STROB_WIDTH-1:0] strb_q;
  logic                       write_q, nsec_q;
  logic [3:0]                 cnt_q;
  logic [APB_ADDR_WIDTH-1:0]  cur_addr, widx;
  logic [APB_DATA_WIDTH-1:0]  rdata;
  logic [IW-1:0]              idx;
  logic                       cur_write, cur_nsec, err, mismatch, unused_prot;
  // Decode from live bus when jumping straight from setup to RESP, else from the captured transfer
  assign cur_addr    = state_q == S_IDLE ? PADDR : addr_q;
  assign cur_write   = state_q == S_IDLE ? PWRITE : write_q;
  assign cur_nsec    = state_q == S_IDLE ? PPROT[1] : nsec_q;
  assign widx        = cur_addr >> OFS;
  assign idx         = widx[IW-1:0];
  assign err         = (|(cur_addr & APB_ADDR_WIDTH'(APB_STROB_WIDTH - 1)))
                     | (widx >= APB_ADDR_WIDTH'(MEM_DEPTH))
                     | (cur_nsec & (widx >= APB_ADDR_WIDTH'(SEC_BASE)));
  assign rdata       = (!cur_write && !err) ? mem_q[idx] : '0;
  assign mismatch    = (PADDR != addr_q) | (PWRITE != write_q) | (PWDATA != data_q);
  assign unused_prot = ^{PPROT[2], PPROT[0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      PREADY   <= 1'b0;
      PRDATA   <= '0;
      PSLVERR  <= 1'b0;
      prot_err <= 1'b0;
      xfer_cnt <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      nsec_q   <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          if (PSEL && PENABLE) prot_err <= 1'b1;
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            data_q  <= PWDATA;
            strb_q  <= PSTROB;
            write_q <= PWRITE;
            nsec_q  <= PPROT[1];
            cnt_q   <= wait_cfg;
            if (!PWRITE && |PSTROB) prot_err <= 1'b1;
            if (wait_cfg == 4'd0) begin
              state_q <= S_RESP;
              PREADY  <= 1'b1;
              PRDATA  <= rdata;
              PSLVERR <= err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            prot_err <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            if (mismatch) prot_err <= 1'b1;
            if (PENABLE) begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                state_q <= S_RESP;
                PREADY  <= 1'b1;
                PRDATA  <= rdata;
                PSLVERR <= err;
              end
            end
          end
        end
        S_RESP: begin
          if (!PSEL) begin
            prot_err <= 1'b1;
            state_q  <= S_IDLE;
            PREADY   <= 1'b0;
            PRDATA   <= '0;
            PSLVERR  <= 1'b0;
          end else begin
            if (mismatch) prot_err <= 1'b1;
            if (PENABLE) begin
              state_q <= S_IDLE;
              PREADY  <= 1'b0;
              PRDATA  <= '0;
              PSLVERR <= 1'b0;
              if (xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
              if (write_q && !err)
                for (int i = 0; i < APB_STROB_WIDTH; i++)
                  if (strb_q[i]) mem_q[idx][8*i +: 8] <= data_q[8*i +: 8];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_slv_mem.md
Name: apb_slv_mem

Overview:
- APB4 completer (slave) memory model, directly downstream of the APB master interface; consumes PSEL/PENABLE/PADDR/PWDATA/PWRITE/PSTROB/PPROT and produces PREADY/PRDATA/PSLVERR.
- Word-addressed RAM with programmable wait states, byte-strobe writes, error response and sticky protocol-violation flag.
- Serves as the DUT endpoint for the APB VIP master agent and monitor.

Parameters:
- APB_ADDR_WIDTH, 32, PADDR width.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width; legal values are 8, 16 and 32.
- APB_STROB_WIDTH, APB_DATA_WIDTH/8, PSTROB width.
- MEM_DEPTH, 256, number of data words; power of two.
- SEC_BASE, MEM_DEPTH/2, first word index of the secure region.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  APB_DATA_WIDTH  write data.
- PSTROB  in  APB_STROB_WIDTH  write byte lanes.
- PPROT  in  3  protection; PPROT[1]=1 means non-secure.
- wait_cfg  in  4  wait states for the next transfer; sampled in the setup phase.
- PREADY  out  1  transfer completion.
- PRDATA  out  APB_DATA_WIDTH  read data.
- PSLVERR  out  1  error response.
- prot_err  out  1  sticky protocol violation.
- xfer_cnt  out  16  completed-transfer count, saturating.

Behaviour:
- Reset (rst=1 at an edge): PREADY=0, PRDATA=0, PSLVERR=0, prot_err=0, xfer_cnt=0, FSM=IDLE, wait counter=0.
- Reset clears all memory words to 0.
- Reset asserted mid-transfer aborts the transfer: no memory write, no count increment.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - PSEL=1 and PENABLE=0 (setup) at an edge: capture PADDR, PWRITE, PWDATA, PSTROB, PPROT and wait_cfg; load counter=wait_cfg.
  - Then go to RESP if wait_cfg==0, otherwise WAIT.
- WAIT:
  - PREADY=0 each access cycle; counter decrements on each edge with PSEL&PENABLE.
  - Go to RESP on the edge where counter==1.
  - Result: exactly wait_cfg cycles with PREADY=0; a transfer takes 2+wait_cfg cycles.
- RESP:
  - PREADY=1, plus PRDATA/PSLVERR, for exactly one cycle.
  - At that edge with PSEL&PENABLE: the transfer completes and the FSM returns to IDLE.
  - Back-to-back setup in the following cycle is accepted normally.
- Error (PSLVERR=1 in the RESP cycle) is raised if any of:
  - PADDR not aligned to APB_STROB_WIDTH bytes;
  - word index >= MEM_DEPTH;
  - PPROT[1]=1 and word index >= SEC_BASE.
- Errored write: memory is unchanged. Errored read: PRDATA=0.
- Write commit occurs on the completion edge. Only lanes with PSTROB[i]=1 update byte i. PSTROB=0 is a legal no-op write.
- Read data:
  - PRDATA = mem[index], loaded on the edge entering RESP.
  - PRDATA = 0 in every non-RESP cycle and for writes.
  - A read returns the value from before any write in the same cycle; none can overlap, since there is one transfer at a time.
- PSLVERR = 0 whenever PREADY = 0.
- xfer_cnt increments by 1 per completion, including errored transfers; saturates at 16'hFFFF.
- prot_err is set, and held until rst, if any of:
  - PENABLE=1 while IDLE with no preceding setup;
  - PSEL drops during WAIT/RESP (the FSM also returns to IDLE, with no commit and no count);
  - PADDR, PWRITE or PWDATA differs from the captured values during WAIT/RESP;
  - PSTROB != 0 on a read setup.
- Address decode uses word index = PADDR >> log2(APB_STROB_WIDTH), truncated compare against MEM_DEPTH; upper PADDR bits must be zero or the access errors.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x10, PSTROB=4'hF, wait_cfg=0; read 0x10 -> write completes in 2 cycles; read PRDATA=32'hDEADBEEF, PSLVERR=0, xfer_cnt=2.
- wait_cfg=3, read 0x10 -> PREADY low for exactly 3 access cycles, high on the 4th; PRDATA valid only in that cycle; total 5 cycles.
- Write 32'h11223344 to 0x20 with PSTROB=4'b0101 over prior 32'hAABBCCDD -> read returns 32'hAA22CC44.
- Read 0x402 (misaligned), then write 0x400 (index 256 >= MEM_DEPTH) -> PSLVERR=1 with PREADY=1; PRDATA=0; memory unchanged; xfer_cnt still increments.
- Non-secure (PPROT=3'b010) write to index 200, then secure (PPROT=3'b000) write to index 200 -> first errors, second succeeds; reading index 200 returns the second value.
- Protocol check: drop PSEL mid-WAIT with wait_cfg=5, and in a separate run assert rst during WAIT -> prot_err=1 with no commit in the first case; in the reset case all outputs are 0 and the following transfer behaves normally.
